mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter: the responder end of the hart's MMIO write interface.
- Accepts store requests on `memory_mapped_io_control` and signals acceptance on `memory_mapped_io_write_complete`. This is the signal the hart's writeback stage stalls on.
- Buffers accepted bytes in a small FIFO and serializes them as 8N1 frames on `tx`.
- Drives a status word on `memory_mapped_io_r_data` so software can poll it.

---
 rtl/mmio_uart_tx_pkg.sv | 48 ++++
 rtl/mmio_uart_tx_fifo.sv | 60 ++++++
 rtl/mmio_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared types for the hart MMIO store path and the UART transmitter:
// store-request struct, width encoding, transmitter state and status layout.
package mmio_uart_tx_pkg;

   localparam int XLEN = 32;

   // Store width as issued by the hart; the UART TX register ignores it.
   typedef enum logic [1:0] {
      WIDTH_BYTE = 2'd0,
      WIDTH_HALF = 2'd1,
      WIDTH_WORD = 2'd2
   } write_width_t;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] value;
      write_width_t    width;
      logic            enable;
   } mem_write_control_t;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_tx_state_t;

   // Status word bit positions.
   localparam int UART_STATUS_BUSY      = 0;
   localparam int UART_STATUS_FULL      = 1;
   localparam int UART_STATUS_EMPTY     = 2;
   localparam int UART_STATUS_COUNT_LSB = 4;

   // Assemble the polled status word; unused bits are zero.
   function automatic logic [XLEN-1:0] uart_status(input logic       busy,
                                                   input logic       full,
                                                   input logic       empty,
                                                   input logic [3:0] count);
      logic [XLEN-1:0] s;
      s = '0;
      s[UART_STATUS_BUSY]                 = busy;
      s[UART_STATUS_FULL]                 = full;
      s[UART_STATUS_EMPTY]                = empty;
      s[UART_STATUS_COUNT_LSB +: 4]       = count;
      return s;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous FIFO with registered occupancy count. Pointers wrap
// naturally; a push and pop in the same cycle leave the count unchanged.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           w_data,
   output logic [WIDTH-1:0]           r_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Overflow/underflow requests are dropped rather than corrupting state.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full   = (count == CNT_MAX);
   assign empty  = (count == '0);
   assign r_data = mem[rd_ptr];

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= w_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: accepts hart byte stores at TX_ADDR into a
// FIFO, serialises them as 8N1 frames on tx, and exposes a polled status word.
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [XLEN-1:0] TX_ADDR      = 32'h0000_1000,
   parameter int              CLKS_PER_BIT = 16,
   parameter int              FIFO_DEPTH   = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  mem_write_control_t memory_mapped_io_control,
   output logic               memory_mapped_io_write_complete,
   output logic [XLEN-1:0]    memory_mapped_io_r_data,
   output logic               tx
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

   // Handshake: the hart holds enable (with addr/value) high until it sees a
   // one-cycle write_complete pulse. armed allows exactly one completion per
   // enable assertion; it re-arms on any cycle with enable low. A mapped store
   // with a full FIFO is simply not completed, so the hart keeps waiting.
   logic armed;
   logic addr_hit;
   logic do_accept;
   logic do_discard;

   logic             fifo_push;
   logic             fifo_pop;
   logic [7:0]       fifo_r_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   uart_tx_state_t    state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;
   logic              baud_last;

   // Upper value bits and the width encoding have no effect on this register.
   logic unused_ctrl_bits;
   assign unused_ctrl_bits = ^{memory_mapped_io_control.value[XLEN-1:8],
                               memory_mapped_io_control.width};

   assign addr_hit   = (memory_mapped_io_control.addr == TX_ADDR);
   assign do_accept  = memory_mapped_io_control.enable && armed && addr_hit && !fifo_full;
   assign do_discard = memory_mapped_io_control.enable && armed && !addr_hit;
   assign fifo_push  = do_accept;

   assign baud_last = (baud_cnt == BAUD_LAST);
   // Pop from IDLE, or at the end of STOP for a back-to-back frame.
   assign fifo_pop  = !fifo_empty &&
                      ((state == UART_IDLE) || ((state == UART_STOP) && baud_last));

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .w_data (memory_mapped_io_control.value[7:0]),
      .r_data (fifo_r_data),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   // Arming flag and registered completion pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         armed                           <= 1'b1;
         memory_mapped_io_write_complete <= 1'b0;
      end else begin
         memory_mapped_io_write_complete <= do_accept || do_discard;
         if (!memory_mapped_io_control.enable) armed <= 1'b1;
         else if (do_accept || do_discard)     armed <= 1'b0;
      end
   end

   // Transmit FSM: baud counter, bit index, shift register and registered tx.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= UART_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         case (state)
            UART_IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               if (fifo_pop) begin
                  shift <= fifo_r_data;
                  tx    <= 1'b0;
                  state <= UART_START;
               end
            end
            UART_START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shift[0];
                  state    <= UART_DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            UART_DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= UART_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            UART_STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (fifo_pop) begin
                     shift <= fifo_r_data;
                     tx    <= 1'b0;
                     state <= UART_START;
                  end else begin
                     tx    <= 1'b1;
                     state <= UART_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            default: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               state    <= UART_IDLE;
            end
         endcase
      end
   end

   // Status word from registered state only; independent of addr.
   always_comb begin
      memory_mapped_io_r_data = uart_status(state != UART_IDLE, fifo_full, fifo_empty,
                                            4'(fifo_count));
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed stores, a serial-line receiver monitor that
// pops expected bytes from a scoreboard queue, and timing checks on pulses.
module tb_mmio_uart_tx;
   import mmio_uart_tx_pkg::*;

   localparam int              C   = 16;
   localparam logic [31:0]     TXA = 32'h0000_1000;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   mem_write_control_t ctrl;
   logic               complete;
   logic [XLEN-1:0]    r_data;
   logic               tx;

   int cyc   = 0;
   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   int         start_q[$];

   mmio_uart_tx #(
      .TX_ADDR      (TXA),
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (4)
   ) dut (
      .clock                           (clock),
      .reset                           (reset),
      .memory_mapped_io_control        (ctrl),
      .memory_mapped_io_write_complete (complete),
      .memory_mapped_io_r_data         (r_data),
      .tx                              (tx)
   );

   // Clock and cycle counter
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
   endtask

   function automatic int start_at(input int idx);
      if (idx < start_q.size()) return start_q[idx];
      return -1;
   endfunction

   // Driver: issue one store and hold it until completion (bounded).
   task automatic mmio_write(input logic [31:0] addr, input logic [7:0] data, input int bound,
                             output int drive_cyc, output int comp_cyc,
                             output logic [31:0] st_comp, output logic [31:0] st_after);
      bit seen;
      @(posedge clock); #1;
      ctrl.addr   = addr;
      ctrl.value  = {24'hC0FFEE, data};
      ctrl.width  = write_width_t'($urandom_range(0, 2));
      ctrl.enable = 1'b1;
      drive_cyc   = cyc;
      seen        = 1'b0;
      comp_cyc    = -1;
      st_comp     = '0;
      for (int k = 0; k < bound && !seen; k++) begin
         @(negedge clock);
         if (complete) begin
            seen     = 1'b1;
            comp_cyc = cyc;
            st_comp  = r_data;
         end
      end
      if (!seen) fail_now("write_complete_timeout");
      else if (addr == TXA) exp_q.push_back(data);
      @(posedge clock); #1;
      ctrl.enable = 1'b0;
      @(negedge clock);
      st_after = r_data;
      check("complete_one_cycle", {31'b0, complete}, 32'd0);
   endtask

   task automatic wait_idle(input int bound, output int c);
      c = -1;
      for (int k = 0; k < bound; k++) begin
         @(negedge clock);
         if (!r_data[UART_STATUS_BUSY]) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) fail_now("busy_drop_timeout");
   endtask

   task automatic rx_wait(input int n, output bit ab);
      ab = 1'b0;
      repeat (n) begin
         @(negedge clock);
         if (reset) ab = 1'b1;
      end
   endtask

   // Scoreboard monitor: receive frames mid-bit and compare with expected bytes.
   initial begin : monitor
      forever begin
         @(negedge clock);
         if (!reset && tx == 1'b0) begin : frame
            bit         ab;
            logic [7:0] b;
            b = '0;
            start_q.push_back(cyc);
            rx_wait(C / 2, ab);
            if (!ab) check("rx_start_bit", {31'b0, tx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
               if (!ab) begin
                  rx_wait(C, ab);
                  b[i] = tx;
               end
            end
            if (!ab) rx_wait(C, ab);
            if (!ab) begin
               check("rx_stop_bit", {31'b0, tx}, 32'd1);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL rx_unexpected_frame: got %0h expected no frame", b);
               end else begin
                  check("rx_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
               end
            end
         end
      end
   end

   // Stimulus
   initial begin : stim
      int          dc, cc, cc6, ic, n0, n1, nc, s;
      logic [31:0] st_c, st_a;
      bit          low;

      ctrl = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clock);
      check("reset_tx", {31'b0, tx}, 32'd1);
      check("reset_status", r_data, 32'h4);
      check("reset_complete", {31'b0, complete}, 32'd0);

      // Single byte 0x55
      n0 = start_q.size();
      mmio_write(TXA, 8'h55, 50, dc, cc, st_c, st_a);
      check("single_complete_latency", cc - dc, 1);
      check("single_status_at_complete", st_c, 32'h10);
      check("single_status_busy", st_a, 32'h05);
      wait_idle(400, ic);
      check("single_frame_count", start_q.size(), n0 + 1);
      check("single_tx_fall_latency", start_at(n0) - dc, 2);
      check("single_frame_length", ic - start_at(n0), 10 * C);
      check("single_rx_done", exp_q.size(), 0);

      // Unmapped write is completed with no effect
      n0 = start_q.size();
      mmio_write(32'h0000_1004, 8'hAA, 50, dc, cc, st_c, st_a);
      check("unmapped_complete_latency", cc - dc, 1);
      check("unmapped_status", st_c, 32'h4);
      low = 1'b0;
      repeat (30) begin
         @(negedge clock);
         if (!tx) low = 1'b1;
      end
      check("unmapped_tx_high", {31'b0, low}, 32'd0);
      check("unmapped_no_frame", start_q.size(), n0);
      check("unmapped_status_after", r_data, 32'h4);

      // Enable held for 10 cycles: one completion, one entry
      n0 = start_q.size();
      @(posedge clock); #1;
      ctrl.addr   = TXA;
      ctrl.value  = 32'h1234_563C;
      ctrl.width  = WIDTH_WORD;
      ctrl.enable = 1'b1;
      exp_q.push_back(8'h3C);
      nc = 0;
      repeat (10) begin
         @(negedge clock);
         if (complete) nc++;
      end
      @(posedge clock); #1;
      ctrl.enable = 1'b0;
      check("held_single_complete", nc, 1);
      wait_idle(400, ic);
      check("held_single_frame", start_q.size(), n0 + 1);
      check("held_rx_done", exp_q.size(), 0);

      // Fill and stall. The first byte leaves the FIFO for the shift register
      // immediately, so six stores are needed to find the FIFO full.
      n0  = start_q.size();
      cc6 = -1;
      for (int i = 1; i <= 6; i++) begin
         mmio_write(TXA, 8'(i), 400, dc, cc, st_c, st_a);
         if (i <= 5) check("fill_complete_latency", cc - dc, 1);
         if (i == 5) check("fill_status_full", st_a, 32'h43);
         if (i == 6) cc6 = cc;
      end
      check("stall_release_after_pop", cc6 - start_at(n0 + 1), 1);
      for (int k = 0; k < 1500 && exp_q.size() != 0; k++) @(negedge clock);
      check("fill_rx_done", exp_q.size(), 0);
      check("fill_frame_count", start_q.size(), n0 + 6);
      for (int i = 0; i < 5; i++)
         check("fill_back_to_back", start_at(n0 + i + 1) - start_at(n0 + i), 10 * C);
      wait_idle(400, ic);

      // Reset mid-frame with two entries queued
      n0 = start_q.size();
      mmio_write(TXA, 8'hA5, 50, dc, cc, st_c, st_a);
      mmio_write(TXA, 8'h11, 50, dc, cc, st_c, st_a);
      s = start_at(n0);
      for (int k = 0; k < 500 && cyc < s + 4 * C + 4; k++) @(negedge clock);
      @(posedge clock); #1;
      ctrl.addr   = TXA;
      ctrl.value  = 32'h0000_0022;
      ctrl.enable = 1'b1;
      @(posedge clock); #3;
      check("pre_reset_complete", {31'b0, complete}, 32'd1);
      check("pre_reset_tx_bit3", {31'b0, tx}, 32'd0);
      check("pre_reset_status", r_data, 32'h21);
      reset = 1'b1;
      #1;
      check("midreset_tx", {31'b0, tx}, 32'd1);
      check("midreset_status", r_data, 32'h4);
      check("midreset_complete", {31'b0, complete}, 32'd0);
      exp_q.delete();
      ctrl.enable = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      n1  = start_q.size();
      low = 1'b0;
      repeat (400) begin
         @(negedge clock);
         if (!tx) low = 1'b1;
      end
      check("post_reset_tx_high", {31'b0, low}, 32'd0);
      check("post_reset_no_frame", start_q.size(), n1);
      check("post_reset_status", r_data, 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
